// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file request scheduler.
package regfile_sched_pkg;

    localparam logic [1:0]  RESP_OK     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_DATA    = 32'hdeaddead;

    // Sized for the largest supported requester count (8).
    localparam int ID_W = 3;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            we;
        logic            err;
    } pipe_t;

endpackage

// File: rtl/regfile_req_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from an eligibility vector, pointer advances past each winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_elig,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_any;
    int            w_idx;

    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_any && i_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = PW'(w_idx);
            end
        end
        o_gnt = w_any ? (N'(1) << w_win) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_req_sched.sv
// Round-robin scheduler sharing one synchronous-read register file among N requesters.
// Define REGFILE_SCHED_PERF_EN to add per-requester grant/stall counters.
module regfile_req_sched
    import regfile_sched_pkg::*;
#(
    parameter int p_num_reqs    = 3,
    parameter int p_addr_nbits  = 32,
    parameter int p_num_entries = 32,
    parameter int p_data_nbits  = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [p_num_reqs-1:0]                req_val,
    output logic [p_num_reqs-1:0]                req_rdy,
    input  logic [p_num_reqs-1:0]                req_we,
    input  logic [p_num_reqs*p_addr_nbits-1:0]   req_addr,
    input  logic [p_num_reqs*p_data_nbits-1:0]   req_data,
    output logic [p_num_reqs-1:0]                resp_val,
    input  logic [p_num_reqs-1:0]                resp_rdy,
    output logic [p_num_reqs*2-1:0]              resp_status,
    output logic [p_num_reqs*p_data_nbits-1:0]   resp_data,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [$clog2(p_num_entries)-1:0]     mem_addr,
    output logic [p_data_nbits-1:0]              mem_wdata,
    input  logic [p_data_nbits-1:0]              mem_rdata
`ifdef REGFILE_SCHED_PERF_EN
    ,
    output logic [p_num_reqs*32-1:0]             perf_grant_cnt,
    output logic [p_num_reqs*32-1:0]             perf_stall_cnt
`endif
);

    localparam int N   = p_num_reqs;
    localparam int AW  = p_addr_nbits;
    localparam int DW  = p_data_nbits;
    localparam int MAW = $clog2(p_num_entries);

    logic [N-1:0]    w_elig_p0;
    logic [N-1:0]    w_gnt_p0;
    logic            w_any_p0;
    logic [ID_W-1:0] w_gid_p0;
    logic [AW-1:0]   w_addr_p0;
    logic [DW-1:0]   w_wdata_p0;
    logic            w_we_p0;
    logic            w_err_p0;

    pipe_t           r_stage_p1;
    logic            r_vld_p1;
    logic [DW-1:0]   w_load_data_p1;

    logic [N-1:0]    r_resp_val_p2;
    logic [N*2-1:0]  r_resp_status_p2;
    logic [N*DW-1:0] r_resp_data_p2;

    // Stage p0: eligibility, arbitration and memory access
    always_comb begin
        w_elig_p0 = '0;
        for (int i = 0; i < N; i++) begin
            w_elig_p0[i] = reset && req_val[i]
                         && !(r_vld_p1 && r_stage_p1.id == ID_W'(i))
                         && (!r_resp_val_p2[i] || resp_rdy[i]);
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_elig (w_elig_p0),
        .o_gnt  (w_gnt_p0)
    );

    always_comb begin
        w_any_p0   = |w_gnt_p0;
        w_gid_p0   = '0;
        w_addr_p0  = '0;
        w_wdata_p0 = '0;
        w_we_p0    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_p0[i]) begin
                w_gid_p0   = ID_W'(i);
                w_addr_p0  = req_addr[i*AW +: AW];
                w_wdata_p0 = req_data[i*DW +: DW];
                w_we_p0    = req_we[i];
            end
        end
        w_err_p0 = (w_addr_p0 >= AW'(p_num_entries));
    end

    assign req_rdy   = w_gnt_p0;
    assign mem_en    = w_any_p0 && !w_err_p0;
    assign mem_we    = mem_en && w_we_p0;
    assign mem_addr  = w_addr_p0[MAW-1:0];
    assign mem_wdata = w_wdata_p0;

    // Stage p1: remember who owns the memory result arriving this cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_any_p0;
        end
        r_stage_p1 <= '{id: w_gid_p0, we: w_we_p0, err: w_err_p0};
    end

    // Writes always return zero data, even when rejected for range.
    always_comb begin
        if (r_stage_p1.we) begin
            w_load_data_p1 = '0;
        end else if (r_stage_p1.err) begin
            w_load_data_p1 = DW'(ERR_DATA);
        end else begin
            w_load_data_p1 = mem_rdata;
        end
    end

    // Stage p2: per-requester response buffers; a load beats a same-cycle drain
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_val_p2    <= '0;
            r_resp_status_p2 <= '0;
            r_resp_data_p2   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_vld_p1 && r_stage_p1.id == ID_W'(i)) begin
                    r_resp_val_p2[i]           <= 1'b1;
                    r_resp_status_p2[i*2 +: 2] <= r_stage_p1.err ? RESP_SLVERR : RESP_OK;
                    r_resp_data_p2[i*DW +: DW] <= w_load_data_p1;
                end else if (resp_rdy[i]) begin
                    r_resp_val_p2[i] <= 1'b0;
                end
            end
        end
    end

    assign resp_val    = r_resp_val_p2;
    assign resp_status = r_resp_status_p2;
    assign resp_data   = r_resp_data_p2;

`ifdef REGFILE_SCHED_PERF_EN
    logic [N*32-1:0] r_perf_grant;
    logic [N*32-1:0] r_perf_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffffffff) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_grant <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_gnt_p0[i]) begin
                    r_perf_grant[i*32 +: 32] <= sat_inc(r_perf_grant[i*32 +: 32]);
                end
                if (req_val[i] && !w_gnt_p0[i]) begin
                    r_perf_stall[i*32 +: 32] <= sat_inc(r_perf_stall[i*32 +: 32]);
                end
            end
        end
    end

    assign perf_grant_cnt = r_perf_grant;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_regfile_req_sched.sv
// Scoreboard bench for regfile_req_sched: stimulus pushes expected responses, a monitor pops and compares.
module tb_regfile_req_sched;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int NE = 32;
    localparam int DW = 32;
    localparam int MAW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_val, req_rdy, req_we, resp_val, resp_rdy;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*2-1:0]    resp_status;
    logic [N*DW-1:0]   resp_data;
    logic              mem_en, mem_we;
    logic [MAW-1:0]    mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
`ifdef REGFILE_SCHED_PERF_EN
    logic [N*32-1:0]   perf_grant_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    regfile_req_sched #(
        .p_num_reqs(N), .p_addr_nbits(AW), .p_num_entries(NE), .p_data_nbits(DW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_status(resp_status), .resp_data(resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef REGFILE_SCHED_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Register-file memory: unwritten entries read back as A000_0000 | address.
    logic [DW-1:0] mem [NE];
    logic          mem_wr [NE];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]    <= mem_wdata;
                mem_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= (mem_wr[mem_addr] === 1'b1) ? mem[mem_addr]
                                                         : (32'hA0000000 | 32'(mem_addr));
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;
    logic [33:0] q0[$], q1[$], q2[$];
    logic [31:0] ref_mem [NE];
    logic        ref_wr [NE];
    logic        s_mem_en, s_mem_we;
    logic [MAW-1:0] s_mem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input int i, input logic [33:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int i, output bit ok, output logic [33:0] v);
        ok = 1'b0;
        v = '0;
        case (i)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic drop_last(input int i);
        case (i)
            0: if (q0.size() > 0) void'(q0.pop_back());
            1: if (q1.size() > 0) void'(q1.pop_back());
            default: if (q2.size() > 0) void'(q2.pop_back());
        endcase
    endtask

    // Expected {status, data} for the request requester g is presenting.
    task automatic model_exp(input int g, output logic [33:0] e);
        logic [31:0] a, d;
        logic        w;
        a = req_addr[g*AW +: AW];
        d = req_data[g*DW +: DW];
        w = req_we[g];
        if (a >= 32'(NE)) begin
            e = {2'b10, (w ? 32'h0 : 32'hdeaddead)};
        end else if (w) begin
            e = {2'b00, 32'h0};
            ref_mem[a[MAW-1:0]] = d;
            ref_wr[a[MAW-1:0]]  = 1'b1;
        end else begin
            e = {2'b00, (ref_wr[a[MAW-1:0]] ? ref_mem[a[MAW-1:0]] : (32'hA0000000 | a))};
        end
    endtask

    task automatic drive(input int i, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        req_val[i] = v;
        req_we[i]  = we;
        req_addr[i*AW +: AW] = addr;
        req_data[i*DW +: DW] = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample the grant of the current cycle, record expectations, advance one cycle.
    task automatic tick(output int g);
        logic [33:0] e;
        #1;
        g = -1;
        for (int i = 0; i < N; i++) if (req_rdy[i]) g = i;
        s_mem_en   = mem_en;
        s_mem_we   = mem_we;
        s_mem_addr = mem_addr;
        if (g >= 0) begin
            model_exp(g, e);
            push_exp(g, e);
        end
        step();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (resp_val[i] && resp_rdy[i]) begin
                    logic [33:0] e, a;
                    bit ok;
                    a = {resp_status[i*2 +: 2], resp_data[i*DW +: DW]};
                    pop_exp(i, ok, e);
                    if (!ok) begin
                        n_total++;
                        $display("FAIL resp%0d_unexpected: got %0h expected none", i, a);
                    end else begin
                        check($sformatf("resp%0d", i), 64'(a), 64'(e));
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        int g;
        int cnt;
        step();
        // Reset held with every requester asking
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 32'(i), 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_req_rdy", 64'(req_rdy), 64'(0));
            check("rst_resp_val", 64'(resp_val), 64'(0));
            check("rst_mem_en", 64'({mem_en, mem_we}), 64'(0));
            step();
        end
        check("rst_resp_stat_data", 64'({resp_status, resp_data}), 64'(0));
        reset = 1'b1;

        // Round robin with everyone reading continuously; first grant goes to 0
        for (int k = 0; k < 9; k++) begin
            tick(g);
            check("rr_order", 64'(g), 64'(k % 3));
        end
        req_val = '0;
        repeat (3) step();

        // Write then read on requester 0
        drive(0, 1'b1, 1'b1, 32'd5, 32'h1234abcd);
        tick(g);
        check("wr_grant", 64'(g), 64'(0));
        check("wr_mem", 64'({s_mem_en, s_mem_we, s_mem_addr}), 64'({2'b11, 5'd5}));
        req_val = '0;
        #1 check("wr_lat_t1", 64'(resp_val[0]), 64'(0));
        step();
        #1 check("wr_resp_val", 64'(resp_val[0]), 64'(1));
        check("wr_resp", 64'({resp_status[1:0], resp_data[31:0]}), 64'({2'b00, 32'h0}));
        drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
        tick(g);
        check("rd_grant", 64'(g), 64'(0));
        check("rd_mem", 64'({s_mem_en, s_mem_we}), 64'(2'b10));
        req_val = '0;
        step();
        #1 check("rd_resp", 64'({resp_val[0], resp_status[1:0], resp_data[31:0]}),
                 64'({1'b1, 2'b00, 32'h1234abcd}));

        // Out-of-range read and write
        drive(1, 1'b1, 1'b0, 32'd32, 32'h0);
        tick(g);
        check("oor_rd_grant", 64'(g), 64'(1));
        check("oor_rd_mem_en", 64'(s_mem_en), 64'(0));
        req_val = '0;
        step();
        #1 check("oor_rd_resp", 64'({resp_status[3:2], resp_data[63:32]}), 64'({2'b10, 32'hdeaddead}));
        drive(2, 1'b1, 1'b1, 32'd40, 32'h55555555);
        tick(g);
        check("oor_wr_grant", 64'(g), 64'(2));
        check("oor_wr_mem_en", 64'(s_mem_en), 64'(0));
        req_val = '0;
        step();
        #1 check("oor_wr_resp", 64'({resp_status[5:4], resp_data[95:64]}), 64'({2'b10, 32'h0}));
        drive(2, 1'b1, 1'b0, 32'd8, 32'h0);
        tick(g);
        req_val = '0;
        step();
        #1 check("oor_mem_kept", 64'(resp_data[95:64]), 64'(32'hA0000008));

        // Backpressure on requester 1
        resp_rdy[1] = 1'b0;
        drive(1, 1'b1, 1'b0, 32'd3, 32'h0);
        tick(g);
        check("bp_fill_grant", 64'(g), 64'(1));
        req_val = '0;
        step();
        step();
        #1 check("bp_full", 64'(resp_val[1]), 64'(1));
        drive(0, 1'b1, 1'b0, 32'd10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd11, 32'h0);
        drive(2, 1'b1, 1'b0, 32'd12, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick(g);
            check("bp_others", 64'(g), 64'((k % 2 == 0) ? 2 : 0));
        end
        resp_rdy[1] = 1'b1;
        tick(g);
        check("bp_release", 64'(g), 64'(1));
        req_val = '0;
        repeat (3) step();

        // Reset in the cycle after a read grant discards the response and re-zeroes the pointer
        drive(1, 1'b1, 1'b0, 32'd7, 32'h0);
        tick(g);
        check("rstmid_grant", 64'(g), 64'(1));
        req_val = '0;
        reset = 1'b0;
        drop_last(1);
        step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("rstmid_no_resp", 64'(resp_val), 64'(0));
            step();
        end
        drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
        drive(2, 1'b1, 1'b0, 32'd2, 32'h0);
        tick(g);
        check("rstmid_ptr", 64'(g), 64'(0));
        req_val = '0;
        repeat (3) step();

`ifdef REGFILE_SCHED_PERF_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(2, 1'b1, 1'b0, 32'd4, 32'h0);
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            tick(g);
            if (g == 2) cnt++;
        end
        req_val = '0;
        check("perf_grants_seen", 64'(cnt), 64'(10));
        check("perf_grant2", 64'(perf_grant_cnt[64 +: 32]), 64'(10));
        check("perf_stall2", 64'(perf_stall_cnt[64 +: 32]), 64'(9));
        check("perf_grant0", 64'(perf_grant_cnt[0 +: 32]), 64'(0));
        repeat (3) step();
`else
        cnt = 0;
`endif
        check("queues_drained", 64'(q0.size() + q1.size() + q2.size() + cnt - cnt), 64'(0));
    endtask

    initial begin
        reset    = 1'b0;
        req_val  = '0;
        req_we   = '0;
        req_addr = '0;
        req_data = '0;
        resp_rdy = '1;
        for (int a = 0; a < NE; a++) begin
            ref_wr[a]  = 1'b0;
            ref_mem[a] = 32'h0;
        end
        fork
            monitor();
            stimulus();
        join_any
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_req_sched.md
Name: regfile_req_sched

Overview:
- Round-robin scheduler that shares one single-port, synchronous-read register-file memory between N requesters.
- Typical requesters: the AXI-Lite write path, the AXI-Lite read path and an FPGA-local engine.
- Grants at most one access per cycle and checks the address range.
- Returns each response through a per-requester one-entry response buffer with a val/rdy handshake.

Parameters:
p_num_reqs, 3, number of requesters N (2..8)
p_addr_nbits, 32, request address width
p_num_entries, 32, register-file depth; legal addresses are 0..p_num_entries-1
p_data_nbits, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets all state)
req_val  in  N  request valid, per requester
req_rdy  out  N  request accepted (grant), per requester
req_we  in  N  1=write, 0=read
req_addr  in  N*p_addr_nbits  request address, requester i at slice i
req_data  in  N*p_data_nbits  write data
resp_val  out  N  response buffer full
resp_rdy  in  N  response consumed
resp_status  out  N*2  2'b00 OK, 2'b10 SLVERR
resp_data  out  N*p_data_nbits  read data; 0 for writes; 32'hdeaddead on error
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  log2(p_num_entries)  memory address
mem_wdata  out  p_data_nbits  memory write data
mem_rdata  in  p_data_nbits  read data, valid the cycle after mem_en

Behaviour:
- Reset values:
  - req_rdy=0, resp_val=0, resp_status=0, resp_data=0, mem_en=0, mem_we=0.
  - RR pointer=0, pipe stage empty.
- Eligibility of requester i in the current cycle requires all of:
  - req_val[i]=1;
  - pipe stage not holding id i;
  - response buffer i empty, or draining this cycle (resp_val[i]&resp_rdy[i]).
- Arbitration:
  - Among eligible requesters, pick the first at or after the pointer, scanning upward with wrap at N.
  - req_rdy is one-hot or zero and is combinational from eligibility.
  - The pointer updates to (winner+1) mod N only on a grant; it holds when there is no grant.
- Grant cycle t:
  - If addr < p_num_entries: mem_en=1, mem_we=req_we, mem_addr=addr low bits, mem_wdata=req_data.
  - If addr is out of range: mem_en=0.
  - The pipe stage captures {id, we, err} at the end of t.
- Cycle t+1: at the end of the cycle, response buffer[id] loads:
  - status: OK, or SLVERR if err;
  - data: mem_rdata for an in-range read, 0 for a write, 32'hdeaddead if err.
- Cycle t+2: resp_val[id]=1. Grant-to-response latency is 2 cycles.
- Throughput:
  - One grant per cycle aggregate.
  - Per requester, at most one new grant every 2 cycles, and only while responses drain with resp_rdy held high.
- Buffer full with resp_rdy=0: the requester is ineligible and other requesters proceed; there is no deadlock.
- Simultaneous drain and load of the same buffer: the load wins and resp_val stays 1.
- Memory contents persist across reset and are not this block's concern.
- Reset mid-operation: the pipe stage and buffers clear and the in-flight response is discarded.
- The pointer wraps from N-1 to 0.

Optional Feature:
- Macro: REGFILE_SCHED_PERF_EN.
- When defined:
  - Adds output perf_grant_cnt, N*32 bits: per-requester grant counters, cleared by reset, saturating at 32'hffffffff.
  - Adds output perf_stall_cnt, N*32 bits: counts cycles with req_val=1 and req_rdy=0, same reset and saturation rules.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package regfile_sched_pkg holds:
  - RESP_OK=2'b00 and RESP_SLVERR=2'b10;
  - ERR_DATA=32'hdeaddead;
  - pipe-stage struct {id, we, err}.
- Sub-module rr_arbiter (parameter N): eligibility vector in, one-hot grant out, owns the pointer register and its update-on-grant rule.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all req_val=1 -> req_rdy=0, resp_val=0, mem_en=0. Release: requester 0 is granted first.
- Single write then read, requester 0: write addr 5, data 32'h1234abcd; then read addr 5. Required:
  - write resp_status=00 and resp_data=0 at t+2;
  - read resp_data=32'h1234abcd at t+2.
- Round robin: all 3 requesters reading continuously with resp_rdy=1 -> grant order 0,1,2,0,1,2...; no requester is granted twice in a row while another is eligible.
- Out of range: read addr 32 and write addr 40 -> mem_en=0 on the grant cycle. Required:
  - read: resp_status=10, resp_data=32'hdeaddead;
  - write: resp_status=10, resp_data=0, and subsequent reads show memory unchanged.
- Backpressure: resp_rdy[1]=0 with buffer 1 full -> requester 1 is never granted while 0 and 2 continue. Raise resp_rdy[1]: buffer drains and requester 1 is granted in the same cycle.
- Reset mid-operation: assert reset in the cycle after a read grant -> no resp_val afterwards, pointer returns to 0.
- Optional feature (REGFILE_SCHED_PERF_EN defined): after 10 grants to requester 2 -> perf_grant_cnt[2]=10.
